// File: rtl/full_adder.sv
// full_adder: single-bit full adder built from two half adders and an OR of their carries.
// Ports:
//   a, b, cin - addend bits and carry-in
//   sum       - a ^ b ^ cin
//   cout      - carry-out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic w_s0;
  logic w_c0;
  logic w_c1;

  half_adder u_ha0 (
    .a     (a),
    .b     (b),
    .sum   (w_s0),
    .carry (w_c0)
  );

  half_adder u_ha1 (
    .a     (w_s0),
    .b     (cin),
    .sum   (sum),
    .carry (w_c1)
  );

  // Both half-adder carries can never be set together, so OR suffices.
  assign cout = w_c0 | w_c1;

endmodule

// File: rtl/half_adder.sv
// half_adder: single-bit half adder.
// Ports:
//   a, b  - addend bits
//   sum   - a ^ b
//   carry - a & b
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one full adder wide, LSB first.
// A start in IDLE or DONE latches a/b/cin; WIDTH SHIFT cycles follow, then a one-cycle DONE.
// Ports:
//   clk, rst_n - rising-edge clock, asynchronous active-low reset
//   start      - begin an addition (accepted in IDLE or DONE only)
//   a, b, cin  - operands and carry-in, sampled on the accepting edge
//   busy       - high while in SHIFT
//   done       - one-cycle pulse while in DONE; sum/cout valid
//   sum, cout  - result, held until the next accepted start
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_d;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic w_accept;
  logic w_last;
  logic w_fa_sum;
  logic w_fa_cout;

  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last   = (r_cnt == LastBit);

  full_adder u_fa (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_carry),
    .sum  (w_fa_sum),
    .cout (w_fa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      IDLE:    if (start) w_state_d = SHIFT;
      SHIFT:   if (w_last) w_state_d = DONE;
      DONE:    w_state_d = start ? SHIFT : IDLE;
      default: w_state_d = IDLE;  // unused encoding recovers to IDLE
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (r_state == SHIFT) begin
      // Sum bits enter at the MSB end so the first bit ends up at bit 0.
      r_sum   <= {w_fa_sum, r_sum[WIDTH-1:1]};
      r_carry <= w_fa_cout;
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      if (w_last) begin
        r_cout <= w_fa_cout;
      end else begin
        r_cnt <= r_cnt + CntW'(1);  // held at LastBit on the final edge, never wraps
      end
    end
  end

  assign busy = (r_state == SHIFT);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks for serial_adder with WIDTH=8.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         cin   = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int vectors     = 0;
  int miscompares = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves the bench at the negedge where done is seen (DONE cycle).
  // Operands are scrambled during SHIFT to show they are ignored there.
  task automatic run_op(input string tag, input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                        input logic cin_v);
    logic [W:0] exp;
    int cyc;
    int bc;
    exp   = {1'b0, a_v} + {1'b0, b_v} + {{W{1'b0}}, cin_v};
    a     = a_v;
    b     = b_v;
    cin   = cin_v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = ~a_v;
    b     = a_v ^ b_v;
    cin   = ~cin_v;
    cyc   = 1;
    bc    = busy ? 1 : 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (busy) bc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(W + 1));
    check({tag, "_busy_cycles"}, 64'(bc), 64'(W));
    check({tag, "_result"}, 64'({cout, sum}), 64'(exp));
  endtask

  initial begin
    int cyc;
    int nd;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;

    // Reset state, including start presented while reset is low.
    #1;
    check("reset_outputs", 64'({busy, done, cout, sum}), 64'(0));
    start = 1'b1;
    a     = 8'h55;
    b     = 8'h66;
    repeat (2) begin
      @(negedge clk);
      check("reset_no_accept", 64'({busy, done}), 64'(0));
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 64'({busy, done, cout, sum}), 64'(0));

    run_op("add_0f_01", 8'h0F, 8'h01, 1'b0);
    // DONE -> IDLE with result held.
    @(negedge clk);
    check("idle_hold_flags", 64'({busy, done}), 64'(0));
    check("idle_hold_result", 64'({cout, sum}), 64'(9'h010));

    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0);
    @(negedge clk);
    run_op("add_ff_ff_c1", 8'hFF, 8'hFF, 1'b1);
    @(negedge clk);

    // Start held high through SHIFT with changing operands: no restart.
    a     = 8'h21;
    b     = 8'h43;
    cin   = 1'b1;
    start = 1'b1;
    cyc   = 0;
    do begin
      @(negedge clk);
      cyc++;
      a = 8'($urandom);
      b = 8'($urandom);
      cin = 1'($urandom);
    end while (!done && cyc < 40);
    check("held_start_latency", 64'(cyc), 64'(W + 1));
    check("held_start_result", 64'({cout, sum}), 64'(9'h065));
    // Back-to-back: start still high in the DONE cycle accepts 0x12 + 0x34.
    a   = 8'h12;
    b   = 8'h34;
    cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("b2b_accepted_busy", 64'({busy, done}), 64'(2'b10));
    check("b2b_sum_cleared", 64'({cout, sum}), 64'(0));
    cyc = 1;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b_latency", 64'(cyc), 64'(W + 1));
    check("b2b_result", 64'({cout, sum}), 64'(9'h046));
    @(negedge clk);

    // Reset during SHIFT cycle 4 aborts the operation.
    a     = 8'h77;
    b     = 8'h11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_abort_busy", 64'(busy), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    check("abort_outputs", 64'({busy, done, cout, sum}), 64'(0));
    start = 1'b1;
    @(negedge clk);
    check("abort_no_accept", 64'({busy, done}), 64'(0));
    start = 1'b0;
    rst_n = 1'b1;
    nd    = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    check("abort_no_done", 64'(nd), 64'(0));
    run_op("after_abort_80_80", 8'h80, 8'h80, 1'b0);

    // Random transactions, chained back-to-back from each DONE cycle.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      run_op($sformatf("rand%0d", i), ra, rb, rc);
      if (i % 3 == 0) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
